// File: rtl/seq_mult_operand_ctrl_pkg.sv
// Shared types and default sizing for the sequential multiplier operand controller.
// Shared by the controller, its bus interface and the benches around it.
package seq_mult_operand_ctrl_pkg;

    localparam int W_DEF           = 6;
    localparam int MULT_CYCLES_DEF = 6;
    localparam int CNT_W_DEF       = 8;
    localparam int PROD_W_DEF      = 2 * W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        OUT  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/seq_mult_operand_ctrl_if.sv
// Bus bundle between the operand controller, its operand source, result sink and the multiplier.
// The master modport is the controller side; slave is everything around it.
interface seq_mult_operand_ctrl_if
    import seq_mult_operand_ctrl_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             mult_load;
    logic             mult_hold;
    logic [W-1:0]     mult_a;
    logic [W-1:0]     mult_b;
    logic [2*W-1:0]   mult_product;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_product;
    logic [CNT_W-1:0] ops_done;

    modport master (
        input  in_valid, in_a, in_b, mult_product, out_ready,
        output in_ready, mult_load, mult_hold, mult_a, mult_b,
               out_valid, out_product, ops_done
    );

    modport slave (
        output in_valid, in_a, in_b, mult_product, out_ready,
        input  in_ready, mult_load, mult_hold, mult_a, mult_b,
               out_valid, out_product, ops_done
    );

endinterface

// File: rtl/seq_mult_operand_ctrl.sv
// Operand/result controller for the right-shift sequential multiplier: accepts one operand pair,
// sequences load/run/hold on the multiplier, captures the product and hands it off downstream.
module seq_mult_operand_ctrl
    import seq_mult_operand_ctrl_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_mult_operand_ctrl_if.master bus
);

    localparam int PROD_W = 2 * W;
    localparam int ITER_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    ctrl_state_e        state_q, state_d;
    logic [ITER_W-1:0]  iterCnt_q, iterCnt_d;
    logic [W-1:0]       multA_q, multA_d;
    logic [W-1:0]       multB_q, multB_d;
    logic [PROD_W-1:0]  outProd_q, outProd_d;
    logic [CNT_W-1:0]   opsDone_q, opsDone_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            iterCnt_q <= '0;
            multA_q   <= '0;
            multB_q   <= '0;
            outProd_q <= '0;
            opsDone_q <= '0;
        end else begin
            state_q   <= state_d;
            iterCnt_q <= iterCnt_d;
            multA_q   <= multA_d;
            multB_q   <= multB_d;
            outProd_q <= outProd_d;
            opsDone_q <= opsDone_d;
        end
    end

    // in_ready is gated by rst so the source sees no acceptance while reset is held,
    // even though the state register already sits in IDLE.
    always_comb begin
        state_d       = state_q;
        iterCnt_d     = iterCnt_q;
        multA_d       = multA_q;
        multB_d       = multB_q;
        outProd_d     = outProd_q;
        opsDone_d     = opsDone_q;
        bus.in_ready  = 1'b0;
        bus.mult_load = 1'b0;
        bus.mult_hold = 1'b1;
        bus.out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = rst;
                if (bus.in_valid) begin
                    multA_d = bus.in_a;
                    multB_d = bus.in_b;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bus.mult_load = 1'b1;
                bus.mult_hold = 1'b0;
                iterCnt_d     = '0;
                state_d       = RUN;
            end
            RUN: begin
                bus.mult_hold = 1'b0;
                iterCnt_d     = iterCnt_q + ITER_W'(1);
                if (iterCnt_q == ITER_W'(MULT_CYCLES - 1)) begin
                    outProd_d = bus.mult_product;
                    state_d   = OUT;
                end
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    opsDone_d = opsDone_q + CNT_W'(1);
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mult_a      = multA_q;
    assign bus.mult_b      = multB_q;
    assign bus.out_product = outProd_q;
    assign bus.ops_done    = opsDone_q;

endmodule

// File: tb/tb_seq_mult_operand_ctrl.sv
// Bench for seq_mult_operand_ctrl: two controllers (8-bit and 2-bit op counters) in lockstep,
// fed by a behavioural shift-add multiplier and checked against plain a*b arithmetic.
module tb_seq_mult_operand_ctrl;
    import seq_mult_operand_ctrl_pkg::*;

    localparam int W  = 6;
    localparam int MC = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inValid = 1'b0;
    logic [5:0] inA = '0;
    logic [5:0] inB = '0;
    logic       outReady = 1'b0;
    logic [11:0] stubAcc;
    int          stubIter;

    int errors = 0;
    int checks = 0;
    int opsCount = 0;

    always #5 clk = ~clk;

    seq_mult_operand_ctrl_if #(.W(W), .CNT_W(8)) ifWide ();
    seq_mult_operand_ctrl_if #(.W(W), .CNT_W(2)) ifNarrow ();

    assign ifWide.in_valid      = inValid;
    assign ifWide.in_a          = inA;
    assign ifWide.in_b          = inB;
    assign ifWide.out_ready     = outReady;
    assign ifWide.mult_product  = stubAcc;
    assign ifNarrow.in_valid     = inValid;
    assign ifNarrow.in_a         = inA;
    assign ifNarrow.in_b         = inB;
    assign ifNarrow.out_ready    = outReady;
    assign ifNarrow.mult_product = stubAcc;

    seq_mult_operand_ctrl #(.W(W), .MULT_CYCLES(MC), .CNT_W(8)) dutWide (
        .clk(clk), .rst(rst), .bus(ifWide)
    );

    seq_mult_operand_ctrl #(.W(W), .MULT_CYCLES(MC), .CNT_W(2)) dutNarrow (
        .clk(clk), .rst(rst), .bus(ifNarrow)
    );

    // Shift-add multiplier stand-in: the load cycle does the first partial product, each
    // unheld cycle after it adds one more, so the product is only complete after W steps.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stubAcc  <= '0;
            stubIter <= W;
        end else if (ifWide.mult_load) begin
            stubAcc  <= ifWide.mult_b[0] ? 12'(ifWide.mult_a) : 12'd0;
            stubIter <= 1;
        end else if (!ifWide.mult_hold && stubIter < W) begin
            if (ifWide.mult_b[stubIter])
                stubAcc <= stubAcc + (12'(ifWide.mult_a) << stubIter);
            stubIter <= stubIter + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One full operation: accept, watch latency, optional backpressure, hand-off.
    task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b,
                                 input int stall, input bit keepValid);
        int waitCyc;
        int lat;
        logic [11:0] expProd;
        expProd  = 12'(a) * 12'(b);
        inA      = a;
        inB      = b;
        inValid  = 1'b1;
        outReady = (stall == 0);
        waitCyc  = 0;
        while (!ifWide.in_ready && waitCyc < 50) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("acceptWait", waitCyc, 0);
        if (waitCyc >= 50) return;
        @(negedge clk);
        checkOutput("loadPulse", {ifWide.mult_load, ifWide.mult_hold}, 2'b10);
        checkOutput("multA", ifWide.mult_a, a);
        checkOutput("multB", ifWide.mult_b, b);
        if (!keepValid) inValid = 1'b0;
        inA = 6'($urandom);
        inB = 6'($urandom);
        lat = 0;
        while (!ifWide.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", lat, MC + 1);
        if (!ifWide.out_valid) return;
        checkOutput("product", ifWide.out_product, expProd);
        checkOutput("productNarrow", ifNarrow.out_product, expProd);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput("stallProduct", ifWide.out_product, expProd);
            checkOutput("stallReadyHold", {ifWide.out_valid, ifWide.in_ready, ifWide.mult_hold}, 3'b101);
            checkOutput("stallOps", ifWide.ops_done, opsCount % 256);
        end
        outReady = 1'b1;
        @(negedge clk);
        opsCount++;
        checkOutput("opsWide", ifWide.ops_done, opsCount % 256);
        checkOutput("opsNarrow", ifNarrow.ops_done, opsCount % 4);
        checkOutput("backToIdle", {ifWide.in_ready, ifWide.out_valid}, 2'b10);
    endtask

    initial begin
        bit sawValid;
        #2;
        checkOutput("resetReady", ifWide.in_ready, 0);
        checkOutput("resetLoadHold", {ifWide.mult_load, ifWide.mult_hold}, 2'b01);
        checkOutput("resetValid", ifWide.out_valid, 0);
        checkOutput("resetRegs", {ifWide.mult_a, ifWide.mult_b, ifWide.out_product, ifWide.ops_done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("releaseReady", ifWide.in_ready, 1);
        @(negedge clk);

        applyStimulus(6'd29, 6'd13, 0, 1'b0);
        applyStimulus(6'd63, 6'd63, 0, 1'b0);
        applyStimulus(6'd0,  6'd45, 0, 1'b0);
        applyStimulus(6'd1,  6'd1,  0, 1'b0);
        applyStimulus(6'd37, 6'd22, 10, 1'b0);
        applyStimulus(6'd5,  6'd7,  0, 1'b1);
        applyStimulus(6'd12, 6'd12, 0, 1'b1);
        applyStimulus(6'd40, 6'd3,  0, 1'b0);

        // Abort an operation part-way through RUN with an asynchronous reset.
        inA = 6'd20; inB = 6'd21; inValid = 1'b1; outReady = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midResetCtl", {ifWide.in_ready, ifWide.mult_load, ifWide.mult_hold, ifWide.out_valid}, 4'b0010);
        checkOutput("midResetRegs", {ifWide.mult_a, ifWide.mult_b, ifWide.out_product, ifWide.ops_done}, 0);
        checkOutput("midResetNarrowOps", ifNarrow.ops_done, 0);
        @(negedge clk);
        rst = 1'b1;
        opsCount = 0;
        sawValid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ifWide.out_valid) sawValid = 1'b1;
        end
        checkOutput("noStaleResult", sawValid, 0);
        applyStimulus(6'd9, 6'd9, 0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            applyStimulus(6'($urandom), 6'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end
        inValid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
